ibus_mem_responder: RTL and testbench

Instruction-bus responder: the memory-side endpoint for the core's instruction fetch port. Accepts one fetch command at a time (`iBus_cmd_*`), reads a 32-bit word from on-chip instruction RAM after a configurable number of wait states, and returns it as a one-cycle response strobe (`iBus_rsp_*`). A side-band load port fills the RAM from the testbench or boot logic.

---
 rtl/ibus_pkg.sv | 20 ++
 rtl/ibus_sync_ram.sv | 40 ++++
 rtl/ibus_mem_responder.sv | 145 ++++++++++++++
 tb/tb_ibus_mem_responder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ibus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ibus_pkg
// Description : Shared types and constants for the instruction-bus responder.
//               - ibus_rsp_state_e : responder FSM state encoding
//               - IBUS_ERR_INST    : instruction word returned on an error
// Revision    : 1.0 - initial release
// ============================================================================
package ibus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } ibus_rsp_state_e;

  localparam logic [31:0] IBUS_ERR_INST = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/ibus_sync_ram.sv
`default_nettype none
// ============================================================================
// Module      : ibus_sync_ram
// Description : Single-clock RAM, one write port and one synchronous read
//               port. A read and a write to the same word on the same edge
//               return the word as it was before the write.
// Ports       : clk            - clock, rising edge
//               we/waddr/wdata - write port
//               re/raddr       - read enable and word address
//               rdata          - read data, updated only on edges with re=1
// Revision    : 1.0 - initial release
// ============================================================================
module ibus_sync_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WIDTH       = 32
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
  output logic [WIDTH-1:0]               rdata
);

  logic [WIDTH-1:0] mem [DEPTH_WORDS];

  // Both ports in one block: the read samples the array before the
  // non-blocking write lands, giving read-before-write behaviour.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/ibus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : ibus_mem_responder
// Description : Memory-side endpoint of the instruction fetch bus. Accepts
//               one fetch at a time, reads on-chip instruction RAM after
//               WAIT_STATES extra cycles and returns the word on a one-cycle
//               response strobe. A side-band load port fills the RAM.
// Ports       : clk, rst (async, active high)
//               iBus_cmd_valid/ready/payload_pc - fetch command
//               iBus_rsp_ready/err/inst         - response strobe and data
//               load_we/addr/data               - RAM fill port
// Config      : IBUS_RESP_MISALIGN_ERR_EN - when defined, a pc with
//               pc[1:0] != 0 produces an error response.
// Revision    : 1.0 - initial release
// ============================================================================
module ibus_mem_responder
  import ibus_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           iBus_cmd_valid,
  output logic                           iBus_cmd_ready,
  input  logic [31:0]                    iBus_cmd_payload_pc,
  output logic                           iBus_rsp_ready,
  output logic                           iBus_rsp_err,
  output logic [31:0]                    iBus_rsp_inst,
  input  logic                           load_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [31:0]                    load_data
);

  localparam int          AW          = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RANGE_BYTES = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  WAIT_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  ibus_rsp_state_e state, state_next;
  logic            accept;
  logic [3:0]      wait_cnt;
  logic [31:0]     offset;
  logic            out_of_range;
  logic            addr_err;
  logic            err_pend;
  logic [31:0]     ram_rdata;

  // Offset from the RAM base; wraps at 32 bits, so addresses below
  // BASE_ADDR become huge and fall out of range naturally.
  assign offset       = iBus_cmd_payload_pc - BASE_ADDR;
  assign out_of_range = ({1'b0, offset} >= RANGE_BYTES);

`ifdef IBUS_RESP_MISALIGN_ERR_EN
  assign addr_err = out_of_range | (iBus_cmd_payload_pc[1:0] != 2'b00);
`else
  assign addr_err = out_of_range;
`endif

  // RESP marks the cycle in which the read data is settled in the RAM
  // output register; the response registers capture it on the next edge.
  always_comb begin
    state_next     = state;
    accept         = 1'b0;
    iBus_cmd_ready = 1'b1;
    case (state)
      IDLE, RESP: begin
        iBus_cmd_ready = 1'b1;
        accept         = iBus_cmd_valid;
        if (iBus_cmd_valid) begin
          state_next = (WAIT_STATES > 0) ? WAIT : RESP;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        iBus_cmd_ready = 1'b0;
        if (wait_cnt == 4'd0) begin
          state_next = RESP;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 4'd0;
    end else if (accept) begin
      wait_cnt <= WAIT_LOAD;
    end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pend <= 1'b0;
    end else if (accept) begin
      err_pend <= addr_err;
    end
  end

  // err/inst update only on a response edge and hold otherwise. On a
  // streaming accept in RESP, err_pend and ram_rdata still carry the
  // previous fetch here because their updates land on this same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iBus_rsp_ready <= 1'b0;
      iBus_rsp_err   <= 1'b0;
      iBus_rsp_inst  <= 32'h0;
    end else begin
      iBus_rsp_ready <= (state == RESP);
      if (state == RESP) begin
        iBus_rsp_err  <= err_pend;
        iBus_rsp_inst <= err_pend ? IBUS_ERR_INST : ram_rdata;
      end
    end
  end

  ibus_sync_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .WIDTH       (32)
  ) u_ram (
    .clk   (clk),
    .we    (load_we),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (accept),
    .raddr (offset[AW+1:2]),
    .rdata (ram_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_ibus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibus_mem_responder
// Description : Self-checking bench for ibus_mem_responder. Two instances:
//               index 0 with WAIT_STATES=1, index 1 with WAIT_STATES=0.
//               Expected responses come from a word-array memory model.
// Config      : honours IBUS_RESP_MISALIGN_ERR_EN in the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibus_mem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid [2];
  logic [31:0] cmd_pc    [2];
  logic        cmd_ready [2];
  logic        rsp_ready [2];
  logic        rsp_err   [2];
  logic [31:0] rsp_inst  [2];
  logic        load_we   [2];
  logic [9:0]  load_addr [2];
  logic [31:0] load_data [2];

  logic [31:0] mem [2][DEPTH];
  int          ws  [2] = '{1, 0};

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ibus_mem_responder #(
      .DEPTH_WORDS (DEPTH),
      .WAIT_STATES ((g == 0) ? 1 : 0),
      .BASE_ADDR   (BASE)
    ) u_dut (
      .clk                 (clk),
      .rst                 (rst),
      .iBus_cmd_valid      (cmd_valid[g]),
      .iBus_cmd_ready      (cmd_ready[g]),
      .iBus_cmd_payload_pc (cmd_pc[g]),
      .iBus_rsp_ready      (rsp_ready[g]),
      .iBus_rsp_err        (rsp_err[g]),
      .iBus_rsp_inst       (rsp_inst[g]),
      .load_we             (load_we[g]),
      .load_addr           (load_addr[g]),
      .load_data           (load_data[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: out of range or (optionally) misaligned gives err, else the word.
  task automatic model(input int d, input logic [31:0] pc,
                       output logic err, output logic [31:0] inst);
    logic [31:0] off;
    off = pc - BASE;
    err = (off >= 32'(DEPTH * 4));
`ifdef IBUS_RESP_MISALIGN_ERR_EN
    if (pc % 4 != 0) err = 1'b1;
`endif
    inst = err ? 32'h0 : mem[d][(off / 4) % DEPTH];
  endtask

  task automatic fetch(input int d, input logic [31:0] pc, input bit ld,
                       input logic [9:0] la, input logic [31:0] ldat);
    logic        e_err;
    logic [31:0] e_inst;
    int          lat;
    model(d, pc, e_err, e_inst);
    @(negedge clk);
    chk("cmd_ready_idle", 32'(cmd_ready[d]), 32'd1);
    cmd_valid[d] = 1'b1;
    cmd_pc[d]    = pc;
    if (ld) begin
      load_we[d]   = 1'b1;
      load_addr[d] = la;
      load_data[d] = ldat;
    end
    @(negedge clk);
    cmd_valid[d] = 1'b0;
    load_we[d]   = 1'b0;
    if (ld) mem[d][la] = ldat;
    lat = 0;
    while (rsp_ready[d] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(ws[d] + 1));
    chk("rsp_err", 32'(rsp_err[d]), 32'(e_err));
    chk("rsp_inst", rsp_inst[d], e_inst);
    @(negedge clk);
    chk("strobe_one_cycle", 32'(rsp_ready[d]), 32'd0);
    chk("inst_hold", rsp_inst[d], e_inst);
  endtask

  initial begin
    int          hits;
    logic [31:0] pc;
    logic [9:0]  la;
    int          d;
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0;
      cmd_pc[i]    = 32'h0;
      load_we[i]   = 1'b0;
      load_addr[i] = 10'h0;
      load_data[i] = 32'h0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_cmd_ready", 32'(cmd_ready[i]), 32'd1);
      chk("rst_rsp_ready", 32'(rsp_ready[i]), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err[i]), 32'd0);
      chk("rst_rsp_inst", rsp_inst[i], 32'd0);
    end
    rst = 1'b0;

    // Fill both RAMs with random words; word 3 gets a known instruction
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        load_we[i]   = 1'b1;
        load_addr[i] = 10'(a);
        load_data[i] = (a == 3) ? 32'h0050_0093 : $urandom;
        mem[i][a]    = load_data[i];
      end
    end
    @(negedge clk);
    load_we[0] = 1'b0;
    load_we[1] = 1'b0;

    // Basic fetch, range boundaries, misalignment
    fetch(0, 32'h0000_000C, 1'b0, 10'd0, 32'h0);
    chk("basic_inst_const", rsp_inst[0], 32'h0050_0093);
    fetch(0, 32'h0000_1000, 1'b0, 10'd0, 32'h0);
    fetch(0, 32'h0000_0FFC, 1'b0, 10'd0, 32'h0);
    fetch(0, 32'h0000_0006, 1'b0, 10'd0, 32'h0);
    fetch(1, 32'hFFFF_FFFC, 1'b0, 10'd0, 32'h0);

    // Same-edge load/fetch collision, then refetch
    fetch(0, 32'h0000_0014, 1'b1, 10'd5, 32'hDEAD_BEEF);
    fetch(0, 32'h0000_0014, 1'b0, 10'd0, 32'h0);
    chk("collision_new", rsp_inst[0], 32'hDEAD_BEEF);

    // Streaming on the zero-wait instance
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk("stream_rsp_ready", 32'(rsp_ready[1]), 32'd1);
        chk("stream_inst", rsp_inst[1], mem[1][i-2]);
      end
      if (i < 4) begin
        cmd_valid[1] = 1'b1;
        cmd_pc[1]    = 32'(4 * i);
      end else begin
        cmd_valid[1] = 1'b0;
      end
    end
    @(negedge clk);
    chk("stream_end", 32'(rsp_ready[1]), 32'd0);

    // Reset in the middle of WAIT drops the pending response
    @(negedge clk);
    cmd_valid[0] = 1'b1;
    cmd_pc[0]    = 32'h0000_0008;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    chk("in_wait_cmd_ready", 32'(cmd_ready[0]), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_wait_cmd_ready", 32'(cmd_ready[0]), 32'd1);
    chk("rst_wait_rsp_ready", 32'(rsp_ready[0]), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    hits = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_ready[0] === 1'b1) hits++;
    end
    chk("no_rsp_after_rst", 32'(hits), 32'd0);

    // Randomised fetches, occasionally colliding with a load
    for (int k = 0; k < 30; k++) begin
      d = k % 2;
      case ($urandom_range(0, 3))
        0:       pc = {20'h0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
        1:       pc = 32'($urandom_range(0, DEPTH * 4 - 1));
        2:       pc = 32'(DEPTH * 4) + 32'($urandom_range(0, 100000));
        default: pc = $urandom;
      endcase
      la = ($urandom_range(0, 1) == 0) ? pc[11:2] : 10'($urandom);
      fetch(d, pc, ($urandom_range(0, 2) == 0), la, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
